// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and the
// log2 helper that sizes the shift-amount port.
package barrel_shifter_pipe_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  function automatic int log2w(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One log level of the barrel shifter: optionally shifts by DIST with the fill
// required by the mode and reports the last bit shifted out as the new carry.
module shift_level import barrel_shifter_pipe_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic             en_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  logic signed [WIDTH-1:0] sdata;
  assign sdata = data_i;

  always_comb begin
    data_o  = data_i;
    carry_o = carry_i;
    if (en_i) begin
      // Right shifts and rotate all lose bit DIST-1 last; only LSL loses from the top.
      carry_o = data_i[DIST-1];
      case (mode_i)
        SH_LSL: begin
          data_o  = data_i << DIST;
          carry_o = data_i[WIDTH-DIST];
        end
        SH_LSR:  data_o = data_i >> DIST;
        SH_ASR:  data_o = sdata >>> DIST;
        default: data_o = (data_i >> DIST) | (data_i << (WIDTH - DIST));
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with valid/ready flow control;
// log levels are grouped into STAGES register stages that collapse bubbles.
module barrel_shifter_pipe import barrel_shifter_pipe_pkg::*; #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  localparam int SW     = log2w(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ShIn,
  input  logic [SW-1:0]    Shamt,
  input  logic [1:0]       Sh,
  input  logic             CarryIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ShOut,
  output logic             CarryOut
);

  localparam int G = (SW + STAGES - 1) / STAGES;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] load;

  assign vld_in = (vld_q << 1) | STAGES'(in_valid);

  // A stage loads when empty or when its successor frees it this cycle.
  always_comb begin
    load = '0;
    load[STAGES-1] = !vld_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) load[k] = !vld_q[k] || load[k+1];
  end

  assign in_ready = load[0];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) vld_q <= '0;
    else         vld_q <= (load & vld_in) | (~load & vld_q);
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stg
    localparam int FIRST = g * G;
    localparam int NL    = (FIRST >= SW) ? 0 : ((SW - FIRST < G) ? (SW - FIRST) : G);

    logic [WIDTH-1:0] in_d, out_d, d_q;
    logic             in_c, out_c, c_q;
    logic [1:0]       in_mode;
    logic [SW-1:0]    in_amt;
    logic             unused_ctl;

    // Stage g input boundary: ports for the first group, previous registers otherwise.
    if (g == 0) begin : g_src
      assign in_d    = ShIn;
      assign in_c    = CarryIn;
      assign in_mode = Sh;
      assign in_amt  = Shamt;
    end else begin : g_src
      assign in_d    = g_stg[g-1].d_q;
      assign in_c    = g_stg[g-1].c_q;
      assign in_mode = g_stg[g-1].g_fwd.mode_q;
      assign in_amt  = g_stg[g-1].g_fwd.amt_q;
    end

    assign unused_ctl = ^{in_mode, in_amt};

    for (genvar i = 0; i < G; i++) begin : g_lvl
      if (i < NL) begin : g_on
        logic [WIDTH-1:0] li_d, lo_d;
        logic             li_c, lo_c;
        if (i == 0) begin : g_head
          assign li_d = in_d;
          assign li_c = in_c;
        end else begin : g_head
          assign li_d = g_lvl[i-1].g_on.lo_d;
          assign li_c = g_lvl[i-1].g_on.lo_c;
        end
        shift_level #(.WIDTH(WIDTH), .DIST(1 << (SW - 1 - FIRST - i))) u_lvl (
          .data_i  (li_d),
          .mode_i  (in_mode),
          .en_i    (in_amt[SW-1-FIRST-i]),
          .carry_i (li_c),
          .data_o  (lo_d),
          .carry_o (lo_c)
        );
      end
    end

    if (NL == 0) begin : g_out
      assign out_d = in_d;
      assign out_c = in_c;
    end else begin : g_out
      assign out_d = g_lvl[NL-1].g_on.lo_d;
      assign out_c = g_lvl[NL-1].g_on.lo_c;
    end

    // Stage g register boundary; only the output stage is cleared by reset.
    if (g == STAGES - 1) begin : g_reg
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          d_q <= '0;
          c_q <= 1'b0;
        end else if (load[g] && vld_in[g]) begin
          d_q <= out_d;
          c_q <= out_c;
        end
      end
    end else begin : g_reg
      always_ff @(posedge CLK) begin
        if (load[g] && vld_in[g]) begin
          d_q <= out_d;
          c_q <= out_c;
        end
      end
    end

    if (g < STAGES - 1) begin : g_fwd
      logic [1:0]    mode_q;
      logic [SW-1:0] amt_q;
      always_ff @(posedge CLK) begin
        if (load[g] && vld_in[g]) begin
          mode_q <= in_mode;
          amt_q  <= in_amt;
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign ShOut     = g_stg[STAGES-1].d_q;
  assign CarryOut  = g_stg[STAGES-1].c_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: directed cases on a 32/2 instance plus random
// traffic with backpressure over several WIDTH/STAGES configurations.
module tb_barrel_shifter_pipe;

  localparam int NC = 7;

  function automatic int cfg_w(input int c);
    case (c)
      0:       return 32;
      1, 2:    return 8;
      3, 4, 5: return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_s(input int c);
    case (c)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      3:       return 1;
      4:       return 4;
      5:       return 6;
      default: return 5;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NC-1:0] iv, ir, ov, orr, cin, cout;
  logic [NC-1:0][63:0] din, dout;
  logic [NC-1:0][5:0]  amt;
  logic [NC-1:0][1:0]  sh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar c = 0; c < NC; c++) begin : g_dut
    localparam int W  = cfg_w(c);
    localparam int S  = cfg_s(c);
    localparam int SWc = $clog2(W);
    logic [W-1:0] sh_out;
    barrel_shifter_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .CLK       (clk),
      .RESETn    (rst_n),
      .in_valid  (iv[c]),
      .in_ready  (ir[c]),
      .ShIn      (din[c][W-1:0]),
      .Shamt     (amt[c][SWc-1:0]),
      .Sh        (sh[c]),
      .CarryIn   (cin[c]),
      .out_valid (ov[c]),
      .out_ready (orr[c]),
      .ShOut     (sh_out),
      .CarryOut  (cout[c])
    );
    assign dout[c] = 64'(sh_out);
  end

  // Reference: each result bit picks its source bit by the mode's rule.
  function automatic logic [64:0] ref_shift(input int w, input logic [63:0] x,
                                            input logic [5:0] a, input logic [1:0] m,
                                            input logic ci);
    logic [63:0] r;
    logic        c;
    int          s;
    s = int'(a) % w;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = (i >= s) ? x[i-s] : 1'b0;
        2'b01:   r[i] = (i + s < w) ? x[i+s] : 1'b0;
        2'b10:   r[i] = (i + s < w) ? x[i+s] : x[w-1];
        default: r[i] = x[(i+s)%w];
      endcase
    end
    if (s == 0) c = ci;
    else begin
      case (m)
        2'b00:   c = x[w-s];
        2'b11:   c = r[w-1];
        default: c = x[s-1];
      endcase
    end
    return {c, r};
  endfunction

  function automatic logic [63:0] rand_word(input int w);
    logic [63:0] x;
    x = {$urandom, $urandom};
    if (w < 64) x = x & ((64'd1 << w) - 64'd1);
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int c, input logic [63:0] x, input logic [5:0] a,
                        input logic [1:0] m, input logic ci);
    din[c] = x;
    amt[c] = a;
    sh[c]  = m;
    cin[c] = ci;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov !== '0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov); end
    step();
    checks++;
    if (dout[0] !== 64'd0 || cout[0] !== 1'b0) begin
      errors++; $display("FAIL reset_payload got %h/%b want 0/0", dout[0], cout[0]);
    end
    checks++;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir[0]); end
    iv[0] = 1'b1;
    set_op(0, 64'h1234, 6'd3, 2'b00, 1'b0);
    step();
    step();
    iv[0] = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_no_accept cycle %0d got %b want 0", k, ov[0]); end
    end
  endtask

  task automatic test_lsl_latency();
    int lat;
    set_op(0, 64'h80000001, 6'd1, 2'b00, 1'b0);
    iv[0] = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL lsl_in_ready got %b want 1", ir[0]); end
    step();
    iv[0] = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 10) begin step(); lat++; end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lsl_latency got %0d want 2", lat); end
    checks++;
    if (dout[0] !== 64'h2 || cout[0] !== 1'b1) begin
      errors++; $display("FAIL lsl_result got %h/%b want 2/1", dout[0], cout[0]);
    end
    step();
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL lsl_consumed got %b want 0", ov[0]); end
  endtask

  task automatic test_modes();
    logic [31:0] tin  [8] = '{32'h80000000, 32'h80000000, 32'h00000001, 32'hA5A5A5A5,
                              32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000003};
    logic [5:0]  tamt [8] = '{6'd31, 6'd31, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd31};
    logic [1:0]  tm   [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic        tci  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tout [8] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'hA5A5A5A5,
                              32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h80000000};
    logic        tco  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int lat;
    for (int t = 0; t < 8; t++) begin
      set_op(0, 64'(tin[t]), tamt[t], tm[t], tci[t]);
      iv[0] = 1'b1;
      step();
      iv[0] = 1'b0;
      lat = 1;
      while (!ov[0] && lat < 10) begin step(); lat++; end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL mode_latency[%0d] got %0d want 2", t, lat); end
      checks++;
      if (dout[0] !== 64'(tout[t]) || cout[0] !== tco[t]) begin
        errors++;
        $display("FAIL mode_result[%0d] got %h/%b want %h/%b", t, dout[0], cout[0], tout[t], tco[t]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ox [8];
    logic [5:0]  oa [8];
    logic [1:0]  om [8];
    logic        oc [8];
    logic [64:0] q[$];
    logic [64:0] exp_v, held;
    logic        held_ok;
    int acc_n, n_out, stall_acc;
    for (int k = 0; k < 8; k++) begin
      ox[k] = rand_word(32);
      oa[k] = 6'($urandom_range(0, 31));
      om[k] = 2'($urandom);
      oc[k] = 1'($urandom);
    end
    acc_n = 0; n_out = 0; stall_acc = 0; held_ok = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
      orr[0] = (cyc >= 5);
      if (acc_n < 8) begin
        iv[0] = 1'b1;
        set_op(0, ox[acc_n], oa[acc_n], om[acc_n], oc[acc_n]);
      end else iv[0] = 1'b0;
      #1;
      if (ov[0] && !orr[0]) begin
        if (held_ok) begin
          checks++;
          if ({cout[0], dout[0]} !== held) begin
            errors++; $display("FAIL stall_stable got %h want %h", {cout[0], dout[0]}, held);
          end
        end else begin
          held = {cout[0], dout[0]};
          held_ok = 1'b1;
        end
      end
      if (ov[0] && orr[0]) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra got result %h want none", dout[0]); end
        else begin
          exp_v = q.pop_front();
          if ({cout[0], dout[0]} !== exp_v) begin
            errors++; $display("FAIL b2b_result[%0d] got %h want %h", n_out, {cout[0], dout[0]}, exp_v);
          end
        end
        n_out++;
      end
      if (iv[0] && ir[0]) begin
        q.push_back(ref_shift(32, ox[acc_n], oa[acc_n], om[acc_n], oc[acc_n]));
        acc_n++;
        if (cyc < 5) stall_acc++;
      end
      step();
    end
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    checks++;
    if (stall_acc !== 2) begin errors++; $display("FAIL b2b_stall_accepts got %0d want 2", stall_acc); end
    checks++;
    if (n_out !== 8 || q.size() !== 0) begin
      errors++; $display("FAIL b2b_count got %0d out %0d left want 8 out 0 left", n_out, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] x;
    logic [5:0]  a;
    logic [1:0]  m;
    logic        ci;
    logic [64:0] exp_v;
    int lat;
    orr[0] = 1'b0;
    iv[0] = 1'b1;
    set_op(0, 64'h0F0F0F0F, 6'd4, 2'b01, 1'b0);
    step();
    set_op(0, 64'hF0F0F0F0, 6'd8, 2'b11, 1'b0);
    step();
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || dout[0] !== 64'd0 || cout[0] !== 1'b0) begin
      errors++; $display("FAIL async_reset got %b/%h/%b want 0/0/0", ov[0], dout[0], cout[0]);
    end
    checks++;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b want 1", ir[0]); end
    orr[0] = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", ov[0]); end
    x = rand_word(32); a = 6'($urandom_range(1, 31)); m = 2'($urandom); ci = 1'($urandom);
    exp_v = ref_shift(32, x, a, m, ci);
    set_op(0, x, a, m, ci);
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 10) begin step(); lat++; end
    checks++;
    if (lat !== 2 || {cout[0], dout[0]} !== exp_v) begin
      errors++; $display("FAIL post_reset got lat %0d %h want lat 2 %h", lat, {cout[0], dout[0]}, exp_v);
    end
    step();
  endtask

  task automatic test_random();
    logic [64:0] qs [NC][$];
    logic [64:0] exp_v;
    int w;
    int consumed = 0;
    for (int cyc = 0; cyc < 1512; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        w = cfg_w(c);
        if (cyc < 1500) begin
          iv[c]  = ($urandom % 4) != 0;
          orr[c] = ($urandom % 10) < 7;
          set_op(c, rand_word(w), 6'($urandom_range(0, w - 1)), 2'($urandom), 1'($urandom));
        end else begin
          iv[c]  = 1'b0;
          orr[c] = 1'b1;
        end
      end
      #1;
      for (int c = 0; c < NC; c++) begin
        if (ov[c] && orr[c]) begin
          checks++;
          consumed++;
          if (qs[c].size() == 0) begin
            errors++; $display("FAIL rand_extra cfg %0d got %h want none", c, dout[c]);
          end else begin
            exp_v = qs[c].pop_front();
            if ({cout[c], dout[c]} !== exp_v) begin
              errors++; $display("FAIL rand_result cfg %0d cycle %0d got %h want %h", c, cyc, {cout[c], dout[c]}, exp_v);
            end
          end
        end
        if (iv[c] && ir[c]) qs[c].push_back(ref_shift(cfg_w(c), din[c], amt[c], sh[c], cin[c]));
      end
      step();
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (qs[c].size() != 0) begin errors++; $display("FAIL rand_lost cfg %0d got %0d left want 0", c, qs[c].size()); end
    end
    checks++;
    if (consumed < 1000) begin errors++; $display("FAIL rand_throughput got %0d want >= 1000", consumed); end
  endtask

  initial begin
    iv = '0;
    orr = '1;
    din = '0;
    amt = '0;
    sh = '0;
    cin = '0;
    test_reset();
    test_lsl_latency();
    test_modes();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
